// File: rtl/hub75_pkg.sv
// Shared types and constants for the HUB75 column driver.
//   pixel_t     : one RGB pixel, [8:6]=R, [5:3]=G, [2:0]=B
//   state_t     : scan FSM states (exported on the debug port)
//   plane_bits  : {R,G,B} bit of a given BCM plane from one pixel
package hub75_pkg;

  localparam int RGB_RES    = 9;
  localparam int NUM_PLANES = RGB_RES / 3;

  // Least significant bit of each colour channel inside a pixel.
  localparam int R_LSB = 6;
  localparam int G_LSB = 3;
  localparam int B_LSB = 0;

  typedef logic [RGB_RES-1:0] pixel_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SHIFT,
    LATCH,
    DISPLAY
  } state_t;

  // Shifting the whole pixel right by the plane index lines up bit `plane`
  // of every channel with that channel's LSB.
  function automatic logic [2:0] plane_bits(input pixel_t px, input logic [1:0] plane);
    pixel_t sh;
    sh = px >> plane;
    return {sh[R_LSB], sh[G_LSB], sh[B_LSB]};
  endfunction

endpackage

// File: rtl/hub75_oe_timer.sv
// BCM display-slot timer. A load pulse starts a slot of BASE_TICKS<<plane
// clocks beginning on the following cycle; oe_n_o is low for the lit part
// of the slot and done_o flags the last clock of the slot.
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   load_i         : start a slot (one-cycle pulse)
//   plane_i        : BCM plane index 0..2, selects slot length
//   brightness_i   : lit fraction (brightness_i+1)/8 of the slot; 7 = full slot
//   oe_n_o         : registered panel output enable, active low
//   done_o         : high during the last clock of the slot
module hub75_oe_timer #(
  parameter int BASE_TICKS = 8,
  parameter int TW         = $clog2((BASE_TICKS << 2) + 1)
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       load_i,
  input  logic [1:0] plane_i,
  input  logic [2:0] brightness_i,
  output logic       oe_n_o,
  output logic       done_o
);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] len_q;
  logic [TW-1:0] on_q;
  logic          active_q;
  logic          oe_n_q;
  logic [TW-1:0] cnt_d;
  logic          last_tick;

  function automatic logic [TW-1:0] slot_len(input logic [1:0] plane);
    return TW'(32'(BASE_TICKS) << plane);
  endfunction

  // Product is formed at 32 bits before the divide-by-8 so nothing wraps.
  function automatic logic [TW-1:0] lit_len(input logic [1:0] plane, input logic [2:0] br);
    int unsigned t;
    t = ((32'(BASE_TICKS) << plane) * (32'(br) + 32'd1)) >> 3;
    return TW'(t);
  endfunction

  assign cnt_d     = cnt_q + 1'b1;
  assign last_tick = (cnt_q == len_q - 1'b1);
  assign done_o    = active_q && last_tick;
  assign oe_n_o    = oe_n_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q    <= '0;
      len_q    <= '0;
      on_q     <= '0;
      active_q <= 1'b0;
      oe_n_q   <= 1'b1;
    end else if (load_i) begin
      cnt_q    <= '0;
      len_q    <= slot_len(plane_i);
      on_q     <= lit_len(plane_i, brightness_i);
      active_q <= 1'b1;
      oe_n_q   <= (lit_len(plane_i, brightness_i) == '0);
    end else if (active_q) begin
      if (last_tick) begin
        cnt_q    <= '0;
        active_q <= 1'b0;
        oe_n_q   <= 1'b1;
      end else begin
        cnt_q  <= cnt_d;
        // Stay lit while the upcoming tick index is inside the lit window.
        oe_n_q <= !(cnt_d < on_q);
      end
    end
  end

endmodule

// File: rtl/hub75_column_driver.sv
// HUB75 column driver: scans every column address of the current rotational
// slice, fetches the column pair from the frame source and shifts it to the
// panel as three BCM planes (shift, latch, display per plane).
// Optional feature macro: HUB75_DIM_EN adds brightness_in, which shortens the
// lit part of each display slot without changing slot length.
//   clk_in, rst_n_in   : clock, asynchronous active-low reset
//   dtheta_in          : current rotational slice
//   dtheta_out         : slice presented to the source, held for a frame
//   column_index_out   : column address presented to the source
//   columns_in         : column pair returned by the source (combinational)
//   rgb1_out, rgb2_out : {R,G,B} plane bits, upper / lower half
//   panel_clk_out      : panel shift clock
//   latch_out          : panel latch strobe
//   oe_n_out           : panel output enable, active low
//   addr_out           : panel scan address
//   frame_done_out     : one-cycle pulse after the last slot of a frame
//   brightness_in      : (HUB75_DIM_EN only) lit fraction, sampled per address
//   dbg_state_out      : current FSM state
// Source interface: there is no valid/ready pair. The source is a pure
// lookup: columns_in must reflect column_index_out/dtheta_out within the
// same cycle, and the driver samples it on the second FETCH cycle.
module hub75_column_driver
  import hub75_pkg::*;
#(
  parameter int SCAN_RATE      = 32,
  parameter int NUM_ROWS       = 64,
  parameter int ROTATIONAL_RES = 256,
  parameter int BASE_TICKS     = 8
) (
  input  logic                              clk_in,
  input  logic                              rst_n_in,
  input  logic [$clog2(ROTATIONAL_RES)-1:0] dtheta_in,
  output logic [$clog2(ROTATIONAL_RES)-1:0] dtheta_out,
  output logic [$clog2(SCAN_RATE)-1:0]      column_index_out,
  input  pixel_t [1:0][NUM_ROWS-1:0]        columns_in,
  output logic [2:0]                        rgb1_out,
  output logic [2:0]                        rgb2_out,
  output logic                              panel_clk_out,
  output logic                              latch_out,
  output logic                              oe_n_out,
  output logic [$clog2(SCAN_RATE)-1:0]      addr_out,
  output logic                              frame_done_out,
`ifdef HUB75_DIM_EN
  input  logic [2:0]                        brightness_in,
`endif
  output state_t                            dbg_state_out
);

  localparam int AW = $clog2(SCAN_RATE);
  localparam int PW = $clog2(NUM_ROWS);
  localparam int DW = $clog2(ROTATIONAL_RES);
  localparam logic [AW-1:0] A_LAST = AW'(SCAN_RATE - 1);
  localparam logic [PW-1:0] P_LAST = PW'(NUM_ROWS - 1);
  localparam logic [1:0]    B_LAST = 2'(NUM_PLANES - 1);

  state_t                    state_q;
  logic                      ph_q;        // cycle within a FETCH or SHIFT step
  logic                      first_q;     // forces a frame after reset
  logic [DW-1:0]             last_dth_q;
  logic [DW-1:0]             dtheta_q;
  logic [AW-1:0]             col_q;
  logic [AW-1:0]             a_q;
  logic [AW-1:0]             addr_q;
  logic [PW-1:0]             p_q;
  logic [1:0]                b_q;
  logic [2:0]                rgb1_q;
  logic [2:0]                rgb2_q;
  logic                      pclk_q;
  logic                      latch_q;
  logic                      done_q;
  pixel_t [1:0][NUM_ROWS-1:0] shadow_q;

  logic [AW-1:0] a_d;
  logic [PW-1:0] p_d;
  logic [1:0]    b_d;
  logic [2:0]    bright;
  logic          slot_done;

  assign a_d = a_q + 1'b1;
  assign p_d = p_q + 1'b1;
  assign b_d = b_q + 1'b1;

`ifdef HUB75_DIM_EN
  logic [2:0] bright_q;
  assign bright = bright_q;
`else
  assign bright = 3'd7;
`endif

  // Shadow copy keeps the shift data stable even if the source moves on.
  always_ff @(posedge clk_in) begin
    if (state_q == FETCH && ph_q) shadow_q <= columns_in;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= IDLE;
      ph_q       <= 1'b0;
      first_q    <= 1'b1;
      last_dth_q <= '0;
      dtheta_q   <= '0;
      col_q      <= '0;
      a_q        <= '0;
      addr_q     <= '0;
      p_q        <= '0;
      b_q        <= '0;
      rgb1_q     <= '0;
      rgb2_q     <= '0;
      pclk_q     <= 1'b0;
      latch_q    <= 1'b0;
      done_q     <= 1'b0;
`ifdef HUB75_DIM_EN
      bright_q   <= '0;
`endif
    end else begin
      latch_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (first_q || dtheta_in != last_dth_q) begin
            first_q    <= 1'b0;
            last_dth_q <= dtheta_in;
            dtheta_q   <= dtheta_in;
            a_q        <= '0;
            col_q      <= '0;
            ph_q       <= 1'b0;
            state_q    <= FETCH;
          end
        end
        FETCH: begin
          if (!ph_q) begin
            ph_q <= 1'b1;
          end else begin
            // OE is high here, so the scan address may move.
            ph_q    <= 1'b0;
            addr_q  <= a_q;
            b_q     <= '0;
            p_q     <= '0;
            pclk_q  <= 1'b0;
            // Shadow loads this same edge, so take pixel 0 from the source.
            rgb1_q  <= plane_bits(columns_in[0][0], 2'd0);
            rgb2_q  <= plane_bits(columns_in[1][0], 2'd0);
`ifdef HUB75_DIM_EN
            bright_q <= brightness_in;
`endif
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (!ph_q) begin
            pclk_q <= 1'b1;
            ph_q   <= 1'b1;
          end else begin
            pclk_q <= 1'b0;
            ph_q   <= 1'b0;
            if (p_q == P_LAST) begin
              rgb1_q  <= '0;
              rgb2_q  <= '0;
              latch_q <= 1'b1;
              state_q <= LATCH;
            end else begin
              p_q    <= p_d;
              rgb1_q <= plane_bits(shadow_q[0][p_d], b_q);
              rgb2_q <= plane_bits(shadow_q[1][p_d], b_q);
            end
          end
        end
        LATCH: begin
          state_q <= DISPLAY;
        end
        DISPLAY: begin
          if (slot_done) begin
            if (b_q != B_LAST) begin
              b_q     <= b_d;
              p_q     <= '0;
              rgb1_q  <= plane_bits(shadow_q[0][0], b_d);
              rgb2_q  <= plane_bits(shadow_q[1][0], b_d);
              state_q <= SHIFT;
            end else if (a_q == A_LAST) begin
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              a_q     <= a_d;
              col_q   <= a_d;
              state_q <= FETCH;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  hub75_oe_timer #(
    .BASE_TICKS(BASE_TICKS)
  ) u_oe_timer (
    .clk_i       (clk_in),
    .rst_n_i     (rst_n_in),
    .load_i      (state_q == LATCH),
    .plane_i     (b_q),
    .brightness_i(bright),
    .oe_n_o      (oe_n_out),
    .done_o      (slot_done)
  );

  assign dtheta_out       = dtheta_q;
  assign column_index_out = col_q;
  assign rgb1_out         = rgb1_q;
  assign rgb2_out         = rgb2_q;
  assign panel_clk_out    = pclk_q;
  assign latch_out        = latch_q;
  assign addr_out         = addr_q;
  assign frame_done_out   = done_q;
  assign dbg_state_out    = state_q;

endmodule

// File: tb/tb_hub75_column_driver.sv
// Bench for hub75_column_driver with SCAN_RATE=2, NUM_ROWS=4, BASE_TICKS=2.
// A small source model answers column fetches; expected per-slot records
// {addr, oe-low clocks, rgb1 shift word, rgb2 shift word} are queued when a
// frame is requested and compared when the panel monitor closes each slot.
module tb_hub75_column_driver;
  import hub75_pkg::*;

  localparam int FRAME_CYC = 2 * (2 + 3 * (2 * 4 + 1) + 7 * 2);

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [7:0]           dtheta_in = 8'd0;
  logic [7:0]           dtheta_out;
  logic [0:0]           column_index;
  logic [1:0][3:0][8:0] columns;
  logic [2:0]           rgb1, rgb2;
  logic                 pclk, latch, oe_n, frame_done;
  logic [0:0]           addr;
  logic [2:0]           bright = 3'd7;
  state_t               dbg_state;

  logic [1:0][3:0][8:0] src [2][2];   // [dtheta parity][column]

  int checks = 0;
  int failures = 0;
  logic [39:0] exp_q[$];
  logic [7:0]  dth_q[$];

  always #5 clk = ~clk;

  always_comb columns = src[dtheta_out[0]][column_index];

  hub75_column_driver #(
    .SCAN_RATE(2), .NUM_ROWS(4), .ROTATIONAL_RES(256), .BASE_TICKS(2)
  ) dut (
    .clk_in          (clk),
    .rst_n_in        (rst_n),
    .dtheta_in       (dtheta_in),
    .dtheta_out      (dtheta_out),
    .column_index_out(column_index),
    .columns_in      (columns),
    .rgb1_out        (rgb1),
    .rgb2_out        (rgb2),
    .panel_clk_out   (pclk),
    .latch_out       (latch),
    .oe_n_out        (oe_n),
    .addr_out        (addr),
    .frame_done_out  (frame_done),
`ifdef HUB75_DIM_EN
    .brightness_in   (bright),
`endif
    .dbg_state_out   (dbg_state)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [2:0] bits_of(input logic [8:0] px, input int b);
    logic [2:0] r, g, bl;
    r = px[8:6]; g = px[5:3]; bl = px[2:0];
    return {r[b], g[b], bl[b]};
  endfunction

  task automatic fill_src(input int par);
    for (int c = 0; c < 2; c++)
      for (int h = 0; h < 2; h++)
        for (int p = 0; p < 4; p++)
          src[par][c][h][p] = 9'($urandom_range(0, 511));
  endtask

  task automatic push_frame(input logic [7:0] dth);
    logic [11:0] d1, d2;
    int lit;
    dth_q.push_back(dth);
    for (int a = 0; a < 2; a++)
      for (int b = 0; b < 3; b++) begin
        d1 = '0; d2 = '0;
        for (int p = 0; p < 4; p++) begin
          d1 = {d1[8:0], bits_of(src[dth[0]][a][0][p], b)};
          d2 = {d2[8:0], bits_of(src[dth[0]][a][1][p], b)};
        end
        lit = ((2 << b) * (int'(bright) + 1)) >> 3;
        exp_q.push_back({8'(a), 8'(lit), d1, d2});
      end
  endtask

  task automatic wait_frame_done(input int max_cyc);
    bit seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk);
      if (frame_done) seen = 1'b1;
    end
    check("frame_done_seen", seen, 1'b1);
  endtask

  task automatic wait_state(input state_t s, input bit need_oe_low, input int max_cyc);
    bit seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk);
      if (dbg_state == s && (!need_oe_low || !oe_n)) seen = 1'b1;
    end
    check("state_reached", seen, 1'b1);
  endtask

  // ---------------- panel monitor ----------------
  logic        prev_pclk, prev_oe, in_win;
  logic [0:0]  prev_addr;
  logic [11:0] sh1, sh2, win_d1, win_d2;
  logic [7:0]  win_addr;
  int          shifts, win_shifts, oe_cnt, mon_plane, frame_cycles;
  int          pclk_rises = 0, oe_low_total = 0;
  logic [11:0] cap1 [2][3];
  logic [11:0] cap2 [2][3];

  task automatic monitor_step();
    if (!rst_n) begin
      prev_pclk = 1'b0; prev_oe = 1'b1; in_win = 1'b0; prev_addr = '0;
      sh1 = '0; sh2 = '0; shifts = 0; oe_cnt = 0; mon_plane = 0; frame_cycles = 0;
      return;
    end
    if (dbg_state != IDLE) frame_cycles++;
    if (addr != prev_addr) check("addr_moves_with_oe_high", oe_n, 1'b1);
    if (pclk && !prev_pclk) begin
      sh1 = {sh1[8:0], rgb1};
      sh2 = {sh2[8:0], rgb2};
      shifts++;
      pclk_rises++;
    end
    if (!oe_n) begin
      oe_low_total++;
      if (in_win) oe_cnt++;
    end
    if (in_win && oe_n && !prev_oe) begin
      in_win = 1'b0;
      check("shifts_per_plane", win_shifts, 4);
      if (exp_q.size() == 0) check("slot_expected", 1'b0, 1'b1);
      else check("slot_record", {win_addr, 8'(oe_cnt), win_d1, win_d2}, exp_q.pop_front());
    end
    if (latch) begin
      in_win = 1'b1; oe_cnt = 0;
      win_addr = 8'(addr); win_d1 = sh1; win_d2 = sh2;
      win_shifts = shifts; shifts = 0;
      cap1[addr][mon_plane] = sh1;
      cap2[addr][mon_plane] = sh2;
      mon_plane = (mon_plane == 2) ? 0 : mon_plane + 1;
      if (dth_q.size() == 0) check("dtheta_expected", 1'b0, 1'b1);
      else check("dtheta_out_held", dtheta_out, dth_q[0]);
    end
    if (frame_done) begin
      check("frame_length", frame_cycles, FRAME_CYC);
      frame_cycles = 0;
      if (dth_q.size() == 0) check("frame_expected", 1'b0, 1'b1);
      else check("dtheta_out_at_done", dtheta_out, dth_q.pop_front());
    end
    prev_pclk = pclk; prev_oe = oe_n; prev_addr = addr;
  endtask

  initial forever begin
    @(negedge clk);
    monitor_step();
  end

  // ---------------- stimulus ----------------
  typedef struct {
    logic [7:0] dth;
    logic [8:0] top, bot;
    logic [8:0] e1, e2;   // {plane0, plane1, plane2} first-shift values
  } vec_t;

  vec_t vecs [4];

  initial begin
    int n_clk, n_oe;
    vecs[0] = '{8'd1, 9'b101_010_111, 9'b000_111_001, 9'b101_011_101, 9'b011_010_010};
    vecs[1] = '{8'd2, 9'b111_111_111, 9'b000_000_000, 9'b111_111_111, 9'b000_000_000};
    vecs[2] = '{8'd3, 9'b100_010_001, 9'b001_100_010, 9'b001_010_100, 9'b100_001_010};
    vecs[3] = '{8'd4, 9'b011_101_110, 9'b110_011_100, 9'b110_101_011, 9'b010_110_101};
    fill_src(0); fill_src(1);

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_oe_n", oe_n, 1'b1);
    check("reset_outputs", {rgb1, rgb2, pclk, latch, frame_done, addr, column_index}, '0);
    check("reset_dtheta_out", dtheta_out, 8'd0);
    check("reset_state", dbg_state, IDLE);

    // First frame after reset runs even with dtheta_in unchanged.
    push_frame(8'd0);
    rst_n = 1'b1;
    wait_frame_done(200);

    // Table: known pixel at column 0 row 0 of each half.
    for (int v = 0; v < 4; v++) begin
      fill_src(int'(vecs[v].dth[0]));
      src[vecs[v].dth[0]][0][0][0] = vecs[v].top;
      src[vecs[v].dth[0]][0][1][0] = vecs[v].bot;
      push_frame(vecs[v].dth);
      dtheta_in = vecs[v].dth;
      wait_frame_done(200);
      for (int b = 0; b < 3; b++) begin
        check($sformatf("vec%0d_top_plane%0d", v, b), cap1[0][b][11:9], vecs[v].e1[8-3*b -: 3]);
        check($sformatf("vec%0d_bot_plane%0d", v, b), cap2[0][b][11:9], vecs[v].e2[8-3*b -: 3]);
      end
    end

    // dtheta 5 -> 6 during address 0: frame 5 completes, then frame 6.
    fill_src(0); fill_src(1);
    push_frame(8'd5);
    dtheta_in = 8'd5;
    wait_state(LATCH, 1'b0, 100);
    dtheta_in = 8'd6;
    push_frame(8'd6);
    wait_frame_done(200);
    wait_frame_done(200);

    // 7 -> 8 -> 9 within a frame: 8 is dropped.
    push_frame(8'd7);
    dtheta_in = 8'd7;
    wait_state(LATCH, 1'b0, 100);
    dtheta_in = 8'd8;
    repeat (5) @(negedge clk);
    dtheta_in = 8'd9;
    push_frame(8'd9);
    wait_frame_done(200);
    wait_frame_done(200);

    // Held dtheta: panel stays idle and dark.
    @(negedge clk);
    n_clk = pclk_rises; n_oe = oe_low_total;
    repeat (40) @(negedge clk);
    check("idle_no_shift", pclk_rises, n_clk);
    check("idle_oe_high", oe_low_total, n_oe);
    check("idle_state", dbg_state, IDLE);

`ifdef HUB75_DIM_EN
    bright = 3'd3;
    fill_src(0);
    push_frame(8'd12);
    dtheta_in = 8'd12;
    wait_frame_done(200);
    bright = 3'd7;
`endif

    // Reset while OE is low: outputs drop at once, then a fresh frame for 0.
    fill_src(0);
    push_frame(8'd10);
    dtheta_in = 8'd10;
    wait_state(DISPLAY, 1'b1, 100);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_oe_n", oe_n, 1'b1);
    check("async_reset_outputs", {rgb1, rgb2, pclk, latch, frame_done}, '0);
    check("async_reset_state", dbg_state, IDLE);
    @(negedge clk);
    exp_q.delete();
    dth_q.delete();
    dtheta_in = 8'd0;
    fill_src(0);
    push_frame(8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_frame_done(200);

    repeat (3) @(negedge clk);
    check("slots_drained", exp_q.size(), 0);
    check("frames_drained", dth_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
